// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequencer: mode encodings, pattern
// width and type, bounce direction, and handshake state encoding.
package pattern_pkg;

    localparam int unsigned PAT_W = 8;

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_ROT    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_GRAY   = 2'd3;

    typedef logic [PAT_W-1:0] pattern_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // IDLE: nothing pending; WAIT_RDY: byte pending, may issue;
    // HOLD: enable just sent, driver has not yet shown it took it.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_HOLD     = 2'd2
    } hs_state_t;

endpackage

// File: rtl/prescaler.sv
// Free-running tick generator: counts 0..N-1 and raises o_tick for exactly
// the one cycle the count equals N-1.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset (count restarts at 0)
//   o_tick  single-cycle tick, registered
module prescaler #(
    parameter int unsigned N = 48_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Tick is registered one count early so it is high while r_cnt == N-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= (r_cnt == CNT_W'(N - 2));
            if (r_cnt == CNT_W'(N - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Generates a display pattern once per prescaled tick and hands each byte
// to the shift-register driver on its ready/enable handshake.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_mode     pattern select: 0 count, 1 rotate-left, 2 bounce, 3 Gray count
//   i_ready    driver idle, may accept a byte
//   o_data     byte to shift out, held from enable until the next enable
//   o_enable   one-cycle request strobe to the driver
//   o_overrun  one-cycle pulse: tick replaced a byte that was never sent
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int unsigned N      = 48_000_000,
    parameter int unsigned DATA_W = PAT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_enable,
    output logic              o_overrun
);

    logic w_tick;

    prescaler #(
        .N (N)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // ---------------------------------------------------------------
    // Pattern generator
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_onehot;
    logic [DATA_W-1:0] r_next;
    dir_t              r_dir;
    logic [1:0]        r_mode;

    logic [DATA_W-1:0] w_cnt_inc;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_bnc;
    dir_t              w_bnc_dir;

    // Candidate next values for each mode; the end bits of the bounce
    // turn around immediately so they are never shown twice in a row.
    always_comb begin
        w_cnt_inc = r_cnt + DATA_W'(1);
        w_rot     = {r_onehot[DATA_W-2:0], r_onehot[DATA_W-1]};
        w_bnc     = r_onehot;
        w_bnc_dir = r_dir;
        if (r_dir == DIR_LEFT) begin
            if (r_onehot[DATA_W-1]) begin
                w_bnc_dir = DIR_RIGHT;
                w_bnc     = r_onehot >> 1;
            end else begin
                w_bnc     = r_onehot << 1;
            end
        end else begin
            if (r_onehot[0]) begin
                w_bnc_dir = DIR_LEFT;
                w_bnc     = r_onehot << 1;
            end else begin
                w_bnc     = r_onehot >> 1;
            end
        end
    end

    // On each tick: reseed on a mode change, otherwise advance the active mode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_onehot <= DATA_W'(1);
            r_dir    <= DIR_LEFT;
            r_mode   <= MODE_COUNT;
            r_next   <= '0;
        end else if (w_tick) begin
            r_mode <= i_mode;
            if (i_mode != r_mode) begin
                r_cnt    <= '0;
                r_onehot <= DATA_W'(1);
                r_dir    <= DIR_LEFT;
                r_next   <= ((i_mode == MODE_ROT) || (i_mode == MODE_BOUNCE))
                            ? DATA_W'(1) : '0;
            end else begin
                case (r_mode)
                    MODE_COUNT: begin
                        r_cnt  <= w_cnt_inc;
                        r_next <= w_cnt_inc;
                    end
                    MODE_ROT: begin
                        r_onehot <= w_rot;
                        r_next   <= w_rot;
                    end
                    MODE_BOUNCE: begin
                        r_onehot <= w_bnc;
                        r_dir    <= w_bnc_dir;
                        r_next   <= w_bnc;
                    end
                    default: begin
                        r_cnt  <= w_cnt_inc;
                        r_next <= w_cnt_inc ^ (w_cnt_inc >> 1);
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Handshake FSM
    // ---------------------------------------------------------------
    hs_state_t r_state;
    logic      r_pending;
    logic      r_hold_seen;
    logic      w_issue;
    logic      w_pend_nxt;

    assign w_issue    = (r_state == ST_WAIT_RDY) && i_ready;
    // A tick always leaves a byte pending, even when it coincides with an issue.
    assign w_pend_nxt = w_tick | (r_pending & ~w_issue);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_WAIT_RDY;
            r_pending   <= 1'b1;
            r_hold_seen <= 1'b0;
            o_data      <= '0;
            o_enable    <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_enable  <= w_issue;
            o_overrun <= w_tick & r_pending & ~w_issue;
            r_pending <= w_pend_nxt;
            if (w_issue) begin
                o_data <= r_next;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pend_nxt) begin
                        r_state <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (w_issue) begin
                        r_state     <= ST_HOLD;
                        r_hold_seen <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Leave on the driver going busy, or after two ready
                    // cycles in case it never saw the strobe.
                    if (!i_ready || r_hold_seen) begin
                        r_state     <= w_pend_nxt ? ST_WAIT_RDY : ST_IDLE;
                        r_hold_seen <= 1'b0;
                    end else begin
                        r_hold_seen <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
